// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, parity modes, parameter checks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

    // Transmit FSM encoding, kept as plain constants so older tools can consume it.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Parity selection values for PARITY_MODE.
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // True when the parameter set describes a frame the framer can produce.
    function automatic bit params_ok(input int sys_clock, input int baudrate,
                                     input int data_bits, input int stop_bits,
                                     input int parity_mode);
        return (baudrate > 0) && (sys_clock >= baudrate) &&
               (data_bits >= 5) && (data_bits <= 9) &&
               (stop_bits == 1 || stop_bits == 2) &&
               (parity_mode >= PARITY_NONE) && (parity_mode <= PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: pulses tick for one clock every BIT_TICKS clocks.
// Latency: restart forces the count to zero on the next clock; first tick BIT_TICKS clocks later.
// Backpressure: none; free-running between restarts.
// Ports: clk, rst_n (async active-low), restart (zero the count), tick (count == BIT_TICKS-1).
module uart_baud_tick #(
    parameter int BIT_TICKS = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);
    localparam int CW = $clog2(BIT_TICKS) + 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_TICKS - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmitter: serialises one word per frame (start, data LSB first, optional parity, stop).
// Latency: start bit on the line the clock after a transfer; each bit lasts SYS_CLOCK/UART_BAUDRATE clocks.
// Backpressure: o_TxReady only in IDLE and in the final stop-bit clock, giving gap-free back-to-back frames.
// Ports: i_SysClock, i_ResetN (async active-low), i_TxValid/o_TxReady/i_TxData word handshake,
//        o_TxSerial line (idle high), o_TxBusy (frame on line), o_TxDone (last stop-bit clock).
// Build option: define UART_TX_PARITY_EN to add the parity bit selected by PARITY_MODE.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int SYS_CLOCK     = 50000000,
    parameter int UART_BAUDRATE = 115200,
    parameter int DATA_BITS     = 8,
    parameter int STOP_BITS     = 1,
    parameter int PARITY_MODE   = 0
) (
    input  logic                 i_SysClock,
    input  logic                 i_ResetN,
    input  logic                 i_TxValid,
    output logic                 o_TxReady,
    input  logic [DATA_BITS-1:0] i_TxData,
    output logic                 o_TxSerial,
    output logic                 o_TxBusy,
    output logic                 o_TxDone
);
    localparam int BIT_TICKS = SYS_CLOCK / UART_BAUDRATE;
    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    generate
        if (!params_ok(SYS_CLOCK, UART_BAUDRATE, DATA_BITS, STOP_BITS, PARITY_MODE)) begin : g_bad_params
            $error("uart_tx_framer: illegal parameter combination");
        end
    endgenerate

    logic [2:0]           state;
    logic [DATA_BITS-1:0] shreg;
    logic [3:0]           bit_idx;
    logic                 stop_idx;
    logic                 tick;
    logic                 fire;
    logic                 last_stop;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_ON = (PARITY_MODE != PARITY_NONE);
    logic par_bit;
`endif

    assign last_stop  = (state == ST_STOP) && tick && (stop_idx == LAST_STOP);
    assign o_TxReady  = (state == ST_IDLE) || last_stop;
    assign fire       = i_TxValid && o_TxReady;
    assign o_TxBusy   = (state != ST_IDLE);
    assign o_TxDone   = last_stop;

    // Restarting on every transfer aligns bit boundaries to the frame start,
    // including a back-to-back frame that begins on the final stop-bit tick.
    uart_baud_tick #(
        .BIT_TICKS (BIT_TICKS)
    ) u_baud_tick (
        .clk     (i_SysClock),
        .rst_n   (i_ResetN),
        .restart (fire),
        .tick    (tick)
    );

    // o_TxSerial is registered alongside the state so each line value
    // appears in the same clock as the state that owns it.
    always_ff @(posedge i_SysClock or negedge i_ResetN) begin
        if (!i_ResetN) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            o_TxSerial <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else if (fire) begin
            state      <= ST_START;
            shreg      <= i_TxData;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            o_TxSerial <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit    <= (PARITY_MODE == PARITY_ODD) ? ~(^i_TxData) : (^i_TxData);
`endif
        end else if (tick) begin
            case (state)
                ST_START: begin
                    state      <= ST_DATA;
                    o_TxSerial <= shreg[0];
                    shreg      <= shreg >> 1;
                end
                ST_DATA: begin
                    if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        if (PAR_ON) begin
                            state      <= ST_PARITY;
                            o_TxSerial <= par_bit;
                        end else begin
                            state      <= ST_STOP;
                            o_TxSerial <= 1'b1;
                        end
`else
                        state      <= ST_STOP;
                        o_TxSerial <= 1'b1;
`endif
                    end else begin
                        bit_idx    <= bit_idx + 1'b1;
                        o_TxSerial <= shreg[0];
                        shreg      <= shreg >> 1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    state      <= ST_STOP;
                    o_TxSerial <= 1'b1;
                end
`endif
                ST_STOP: begin
                    if (stop_idx == LAST_STOP) begin
                        state      <= ST_IDLE;
                        o_TxSerial <= 1'b1;
                    end else begin
                        stop_idx <= stop_idx + 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    o_TxSerial <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Self-checking bench for uart_tx_framer at 10 clocks per bit.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_framer;
`ifdef UART_TX_PARITY_EN
    localparam int NI = 4;
`else
    localparam int NI = 2;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NI-1:0] valid = '0;
    logic [7:0]    txd8 [NI];
    logic [4:0]    txd5 = '0;
    wire  [NI-1:0] rdy, ser, busy, done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // inst 0: 8N1
    uart_tx_framer #(.SYS_CLOCK(1000000), .UART_BAUDRATE(100000), .DATA_BITS(8),
                     .STOP_BITS(1), .PARITY_MODE(0)) u_8n1 (
        .i_SysClock(clk), .i_ResetN(rst_n), .i_TxValid(valid[0]), .o_TxReady(rdy[0]),
        .i_TxData(txd8[0]), .o_TxSerial(ser[0]), .o_TxBusy(busy[0]), .o_TxDone(done[0]));

    // inst 1: 5N2
    uart_tx_framer #(.SYS_CLOCK(1000000), .UART_BAUDRATE(100000), .DATA_BITS(5),
                     .STOP_BITS(2), .PARITY_MODE(0)) u_5n2 (
        .i_SysClock(clk), .i_ResetN(rst_n), .i_TxValid(valid[1]), .o_TxReady(rdy[1]),
        .i_TxData(txd5), .o_TxSerial(ser[1]), .o_TxBusy(busy[1]), .o_TxDone(done[1]));

`ifdef UART_TX_PARITY_EN
    // inst 2: 8E1, inst 3: 8O1
    uart_tx_framer #(.SYS_CLOCK(1000000), .UART_BAUDRATE(100000), .DATA_BITS(8),
                     .STOP_BITS(1), .PARITY_MODE(1)) u_8e1 (
        .i_SysClock(clk), .i_ResetN(rst_n), .i_TxValid(valid[2]), .o_TxReady(rdy[2]),
        .i_TxData(txd8[2]), .o_TxSerial(ser[2]), .o_TxBusy(busy[2]), .o_TxDone(done[2]));

    uart_tx_framer #(.SYS_CLOCK(1000000), .UART_BAUDRATE(100000), .DATA_BITS(8),
                     .STOP_BITS(1), .PARITY_MODE(2)) u_8o1 (
        .i_SysClock(clk), .i_ResetN(rst_n), .i_TxValid(valid[3]), .o_TxReady(rdy[3]),
        .i_TxData(txd8[3]), .o_TxSerial(ser[3]), .o_TxBusy(busy[3]), .o_TxDone(done[3]));
`endif

    // frame: line bits in transmit order, bit 0 = start bit
    typedef struct {
        int         inst;
        logic [7:0] data;
        logic [11:0] frame;
        int         nb;
    } vec_t;

    vec_t vecs[7];
    int   nv;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic drive(input int inst, input logic [7:0] d);
        if (inst == 1) txd5 = d[4:0];
        else txd8[inst] = d;
    endtask

    // Called at a negedge; returns at the negedge of the first clock after the frame.
    task automatic run_frame(input int vi, input int inst, input logic [7:0] d,
                             input logic [11:0] frame, input int nb);
        logic [11:0] mid;
        int unstable, busy_low, done_cnt, done_at, nclk;
        string tag;
        tag = $sformatf("v%0d", vi);
        mid = '0; unstable = 0; busy_low = 0; done_cnt = 0; done_at = -1;
        nclk = nb * 10;
        chk({tag, "_ready_idle"}, rdy[inst], 1);
        drive(inst, d);
        valid[inst] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid[inst] = 1'b0;
        drive(inst, ~d);  // must be ignored after capture
        for (int k = 1; k <= nclk; k++) begin
            if (ser[inst] !== frame[(k-1)/10]) unstable++;
            if ((k % 10) == 5) mid[(k-1)/10] = ser[inst];
            if (busy[inst] !== 1'b1) busy_low++;
            if (done[inst] === 1'b1) begin done_cnt++; done_at = k; end
            @(negedge clk);
        end
        for (int b = 0; b < nb; b++)
            chk($sformatf("%s_bit%0d", tag, b), mid[b], frame[b]);
        chk({tag, "_bad_clocks"}, unstable, 0);
        chk({tag, "_busy_low"}, busy_low, 0);
        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_done_clock"}, done_at, nclk);
        chk({tag, "_idle_line"}, ser[inst], 1);
        chk({tag, "_idle_busy"}, busy[inst], 0);
        chk({tag, "_idle_ready"}, rdy[inst], 1);
    endtask

    initial begin
        int d1, d2, dcnt, busy_low, bad;
        logic [11:0] f1, f2;

        for (int i = 0; i < NI; i++) txd8[i] = '0;

        vecs[0] = '{0, 8'hA5, 12'h34A, 10};  // 0 10100101 1
        vecs[1] = '{0, 8'h00, 12'h200, 10};
        vecs[2] = '{0, 8'hFF, 12'h3FE, 10};
        vecs[3] = '{1, 8'h1F, 12'h0FE, 8};   // 0 11111 1 1
        vecs[4] = '{1, 8'h0A, 12'h0D4, 8};   // 0 01010 1 1
        nv = 5;
`ifdef UART_TX_PARITY_EN
        vecs[5] = '{2, 8'h07, 12'h60E, 11};  // even parity of 0x07 -> 1
        vecs[6] = '{3, 8'h07, 12'h40E, 11};  // odd parity of 0x07 -> 0
        nv = 7;
`endif

        // Reset state
        @(negedge clk);
        chk("rst_ready", rdy[0], 1);
        chk("rst_line", ser[0], 1);
        chk("rst_busy", busy[0], 0);
        chk("rst_done", done[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int v = 0; v < nv; v++)
            run_frame(v, vecs[v].inst, vecs[v].data, vecs[v].frame, vecs[v].nb);

        // Back-to-back: valid held high, 0x55 then 0x0F
        f1 = 12'h2AA;  // 0 10101010 1
        f2 = 12'h21E;  // 0 11110000 1
        d1 = -1; d2 = -1; dcnt = 0; busy_low = 0; bad = 0;
        txd8[0] = 8'h55;
        valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        txd8[0] = 8'h0F;
        for (int k = 1; k <= 200; k++) begin
            if (k <= 100) begin
                if (ser[0] !== f1[(k-1)/10]) bad++;
            end else begin
                if (ser[0] !== f2[(k-101)/10]) bad++;
            end
            if (busy[0] !== 1'b1) busy_low++;
            if (done[0] === 1'b1) begin
                dcnt++;
                if (d1 < 0) d1 = k; else d2 = k;
            end
            @(negedge clk);
            if (k == 150) valid[0] = 1'b0;
        end
        chk("b2b_bad_clocks", bad, 0);
        chk("b2b_busy_low", busy_low, 0);
        chk("b2b_done_count", dcnt, 2);
        chk("b2b_done1", d1, 100);
        chk("b2b_done_gap", d2 - d1, 100);
        chk("b2b_no_third", busy[0], 0);
        chk("b2b_idle_line", ser[0], 1);

        // Reset at clock 45 of a 0x00 frame (data bit 3 on the line)
        txd8[0] = 8'h00;
        valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid[0] = 1'b0;
        repeat (44) @(negedge clk);
        chk("rst45_line_before", ser[0], 0);
        rst_n = 1'b0;
        #1;
        chk("rst45_line", ser[0], 1);
        chk("rst45_busy", busy[0], 0);
        chk("rst45_done", done[0], 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst45_ready", rdy[0], 1);
        bad = 0;
        for (int k = 0; k < 120; k++) begin
            if (ser[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("rst45_residual", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 SHALL have parameter SYS_CLOCK, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter UART_BAUDRATE, default 115200, line bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal range 5..9.
REQ-004 SHALL have parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-005 SHALL have parameter PARITY_MODE, default 0, 0=none, 1=even, 2=odd; effective only per REQ-024.
REQ-006 SHALL have port i_SysClock  input  1  system clock, all logic on rising edge.
REQ-007 SHALL have port i_ResetN  input  1  asynchronous active-low reset.
REQ-008 SHALL have port i_TxValid  input  1  upstream word valid.
REQ-009 SHALL have port o_TxReady  output  1  block accepts word this cycle.
REQ-010 SHALL have port i_TxData  input  DATA_BITS  word to send, LSB first.
REQ-011 SHALL have port o_TxSerial  output  1  registered serial line, idle high.
REQ-012 SHALL have port o_TxBusy  output  1  high while any frame bit is on the line.
REQ-013 SHALL have port o_TxDone  output  1  one-cycle pulse in last clock of final stop bit.

Function
REQ-014 SHALL define BIT_TICKS = SYS_CLOCK/UART_BAUDRATE (integer division); every line bit lasts exactly BIT_TICKS clocks.
REQ-015 SHALL transfer a word when i_TxValid and o_TxReady are both high on a rising edge; i_TxData captured then, later changes ignored.
REQ-016 SHALL use states IDLE, START, DATA, PARITY, STOP; IDLE->START on transfer; START->DATA after one bit; DATA->PARITY (parity on) or STOP after DATA_BITS bits; PARITY->STOP after one bit; STOP->START on transfer in its last clock, else ->IDLE after STOP_BITS bits.
REQ-017 SHALL drive o_TxReady high in IDLE and in the last clock of the final stop bit only; low otherwise.
REQ-018 SHALL drive o_TxSerial low in the clock following a transfer from IDLE (latency 1); data LSB first; parity = XOR of data (even) or its inverse (odd); stop bits high.
REQ-019 SHALL, on back-to-back transfer, start the next start bit in the clock after the last stop-bit clock, with zero idle gap.
REQ-020 SHALL restart the bit-tick counter at zero at each frame start; counter width $clog2(BIT_TICKS)+1.
REQ-021 SHALL hold o_TxBusy high from first start-bit clock to last stop-bit clock inclusive, continuously across back-to-back frames.
REQ-022 SHALL ignore i_TxValid whenever o_TxReady is low; no word is lost or duplicated.

Reset
REQ-023 SHALL on i_ResetN low, immediately and mid-frame: state IDLE, o_TxSerial 1, o_TxReady 1 after release, o_TxBusy 0, o_TxDone 0, counters 0; aborted frame is not resumed.

Configuration
REQ-024 SHALL compile parity logic and PARITY state only when macro UART_TX_PARITY_EN is defined; without it, PARITY_MODE is ignored, frames are start+data+stop, and no parity registers exist.

Structure
REQ-025 SHALL take state encoding, parity-mode constants and parameter-range checks from shared package uart_pkg.
REQ-026 SHALL instantiate sub-module uart_baud_tick (counter, restart input, one-cycle tick at BIT_TICKS-1).

Verification (SYS_CLOCK=1000000, UART_BAUDRATE=100000, BIT_TICKS=10)
REQ-027 SHALL check: DATA_BITS=8, no parity, send 0xA5 -> line low 10 clks, then 1,0,1,0,0,1,0,1 at 10 clks each, high 10 clks, o_TxDone at clock 100.
REQ-028 SHALL check: UART_TX_PARITY_EN, PARITY_MODE=1, send 0x07 -> parity bit 1; PARITY_MODE=2 -> 0; frame 110 clks.
REQ-029 SHALL check: i_TxValid held high with 0x55 then 0x0F -> second start bit immediately after first stop bit, o_TxBusy never drops, two o_TxDone pulses 100 clks apart.
REQ-030 SHALL check: DATA_BITS=5, STOP_BITS=2, send 0x1F -> frame 80 clks, 20 high clks at end.
REQ-031 SHALL check: i_ResetN low at clock 45 of a frame -> o_TxSerial 1 same cycle, after release o_TxReady 1, no residual bits.
